// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_ctrl
// Description : Per-frame controller for one 32x32 player sprite. Converts
//               joystick levels and a kill pulse into the renderer's
//               configuration (top-left position and sprite index). All state
//               advances only on frame_tick so the renderer sees stable
//               values for the whole active frame.
// Ports       : clk                - system/pixel clock
//               reset_n            - asynchronous active-low reset
//               frame_tick         - one-cycle pulse per frame (vblank)
//               btn_up/down/left/right - synchronised direction levels
//               kill               - one-cycle pulse, player was hit
//               centerX/centerY    - signed 11-bit sprite top-left
//               sprite_num         - sprite index 0..6
//               alive              - low while the death sprite is shown
// Revision    : 1.0 - initial release
// ============================================================================
module player_ctrl #(
    parameter int STEP         = 2,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 768,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 568,
    parameter int SPAWN_X      = 32,
    parameter int SPAWN_Y      = 32,
    parameter int ANIM_DIV     = 8,
    parameter int DEATH_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               kill,
    output logic signed [10:0] centerX,
    output logic signed [10:0] centerY,
    output logic [2:0]         sprite_num,
    output logic               alive
);

    localparam int c_ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int c_DEATH_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_WALK  = 2'd1;
    localparam logic [1:0] c_S_DYING = 2'd2;

    // Direction codes equal the standing-sprite indices.
    localparam logic [1:0] c_D_DOWN  = 2'd0;
    localparam logic [1:0] c_D_UP    = 2'd1;
    localparam logic [1:0] c_D_LEFT  = 2'd2;
    localparam logic [1:0] c_D_RIGHT = 2'd3;

    localparam logic [2:0] c_SPR_WALK_V = 3'd4;
    localparam logic [2:0] c_SPR_WALK_H = 3'd5;
    localparam logic [2:0] c_SPR_DEATH  = 3'd6;

    localparam logic signed [10:0]  c_SPAWN_X    = 11'(SPAWN_X);
    localparam logic signed [10:0]  c_SPAWN_Y    = 11'(SPAWN_Y);
    localparam logic [c_ANIM_W-1:0]  c_ANIM_LAST  = c_ANIM_W'(ANIM_DIV - 1);
    localparam logic [c_DEATH_W-1:0] c_DEATH_LAST = c_DEATH_W'(DEATH_FRAMES - 1);

    // One step in 12-bit signed arithmetic, clamped before truncation so the
    // position can never wrap.
    function automatic logic signed [10:0] f_step(
        input logic signed [10:0] pos,
        input logic               inc,
        input int                 lo,
        input int                 hi
    );
        logic signed [11:0] v_ext;
        logic signed [11:0] v_nxt;
        v_ext = 12'(pos);
        v_nxt = inc ? (v_ext + 12'(STEP)) : (v_ext - 12'(STEP));
        if (v_nxt < 12'(lo)) begin
            v_nxt = 12'(lo);
        end else if (v_nxt > 12'(hi)) begin
            v_nxt = 12'(hi);
        end
        return v_nxt[10:0];
    endfunction

    logic [1:0]           state_q, state_d;
    logic [1:0]           dir_q, dir_d;
    logic [c_ANIM_W-1:0]  anim_q, anim_d;
    logic                 phase_q, phase_d;
    logic [c_DEATH_W-1:0] death_q, death_d;
    logic                 pend_q, pend_d;
    logic signed [10:0]   cx_q, cx_d;
    logic signed [10:0]   cy_q, cy_d;
    logic [2:0]           spr_q, spr_d;
    logic                 alive_q, alive_d;

    logic                 w_any;
    logic [1:0]           w_dir;
    logic signed [10:0]   w_cx_step;
    logic signed [10:0]   w_cy_step;

    assign w_any = btn_up | btn_down | btn_left | btn_right;

    // Priority up > down > left > right; only one axis moves per frame.
    always_comb begin
        w_dir = c_D_RIGHT;
        if (btn_up) begin
            w_dir = c_D_UP;
        end else if (btn_down) begin
            w_dir = c_D_DOWN;
        end else if (btn_left) begin
            w_dir = c_D_LEFT;
        end
    end

    always_comb begin
        w_cx_step = cx_q;
        w_cy_step = cy_q;
        case (w_dir)
            c_D_UP:   w_cy_step = f_step(cy_q, 1'b0, Y_MIN, Y_MAX);
            c_D_DOWN: w_cy_step = f_step(cy_q, 1'b1, Y_MIN, Y_MAX);
            c_D_LEFT: w_cx_step = f_step(cx_q, 1'b0, X_MIN, X_MAX);
            default:  w_cx_step = f_step(cx_q, 1'b1, X_MIN, X_MAX);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_S_IDLE;
            dir_q   <= c_D_DOWN;
            anim_q  <= '0;
            phase_q <= 1'b0;
            death_q <= '0;
            pend_q  <= 1'b0;
            cx_q    <= c_SPAWN_X;
            cy_q    <= c_SPAWN_Y;
            spr_q   <= 3'd0;
            alive_q <= 1'b1;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            anim_q  <= anim_d;
            phase_q <= phase_d;
            death_q <= death_d;
            pend_q  <= pend_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            spr_q   <= spr_d;
            alive_q <= alive_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        anim_d  = anim_q;
        phase_d = phase_q;
        death_d = death_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        spr_d   = spr_q;
        alive_d = alive_q;
        // A kill on a tick cycle only latches here; IDLE/WALK act on the
        // previously latched value, so it takes effect one tick later.
        pend_d  = pend_q | (kill & (state_q != c_S_DYING));

        if (frame_tick) begin
            case (state_q)
                c_S_IDLE, c_S_WALK: begin
                    if (pend_q) begin
                        state_d = c_S_DYING;
                        death_d = '0;
                        spr_d   = c_SPR_DEATH;
                        alive_d = 1'b0;
                        pend_d  = 1'b0;
                    end else if (!w_any) begin
                        state_d = c_S_IDLE;
                        phase_d = 1'b0;
                        spr_d   = {1'b0, dir_q};
                    end else begin
                        state_d = c_S_WALK;
                        dir_d   = w_dir;
                        cx_d    = w_cx_step;
                        cy_d    = w_cy_step;
                        if (state_q == c_S_IDLE) begin
                            anim_d  = '0;
                            phase_d = 1'b0;
                        end else if (anim_q == c_ANIM_LAST) begin
                            anim_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            anim_d  = anim_q + 1'b1;
                        end
                        if (phase_d) begin
                            spr_d = w_dir[1] ? c_SPR_WALK_H : c_SPR_WALK_V;
                        end else begin
                            spr_d = {1'b0, w_dir};
                        end
                    end
                end
                c_S_DYING: begin
                    if (death_q == c_DEATH_LAST) begin
                        state_d = c_S_IDLE;
                        death_d = '0;
                        cx_d    = c_SPAWN_X;
                        cy_d    = c_SPAWN_Y;
                        dir_d   = c_D_DOWN;
                        spr_d   = 3'd0;
                        alive_d = 1'b1;
                        anim_d  = '0;
                        phase_d = 1'b0;
                    end else begin
                        death_d = death_q + 1'b1;
                    end
                end
                default: begin
                    state_d = c_S_IDLE;
                end
            endcase
        end
    end

    // Output logic: everything is registered, outputs are direct copies.
    always_comb begin
        centerX    = cx_q;
        centerY    = cy_q;
        sprite_num = spr_q;
        alive      = alive_q;
    end

endmodule
`default_nettype wire

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Per-frame controller for one 32x32 player sprite renderer.
- Turns joystick requests and a kill event into the renderer's configuration: top-left position (centerX/centerY, signed 11-bit) and sprite_num (0..6).
- Sits between input synchronisers / game logic and the sprite ROM block.
- All state advances only on frame_tick, so the renderer sees stable values for the whole active frame.

Parameters:
- STEP, 2, pixels moved per frame while a direction is held.
- X_MIN, 0, minimum top-left X.
- X_MAX, 768, maximum top-left X (HACTIVE-32).
- Y_MIN, 0, minimum top-left Y.
- Y_MAX, 568, maximum top-left Y (VACTIVE-32).
- SPAWN_X, 32, X after reset and after respawn.
- SPAWN_Y, 32, Y after reset and after respawn.
- ANIM_DIV, 8, frames per walk-animation phase (>=1).
- DEATH_FRAMES, 60, frames the death sprite is shown (>=1).

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame, during vertical blanking.
- btn_up  in  1  move-up request, level, already synchronised.
- btn_down  in  1  move-down request.
- btn_left  in  1  move-left request.
- btn_right  in  1  move-right request.
- kill  in  1  one-cycle pulse: player hit by explosion.
- centerX  out  11 signed  sprite top-left X.
- centerY  out  11 signed  sprite top-left Y.
- sprite_num  out  3  sprite index 0..6.
- alive  out  1  1 unless dying.

Behaviour:
- Reset values (asynchronous, reset_n low):
  - centerX=SPAWN_X, centerY=SPAWN_Y
  - sprite_num=0, alive=1
  - state=IDLE, dir=DOWN, anim_cnt=0, phase=0, death_cnt=0, kill_pend=0
- Sprite map:
  - 0 stand down, 1 stand up, 2 stand left, 3 stand right
  - 4 walk vertical, 5 walk horizontal, 6 death
  - 7 is never driven.
- Kill handling:
  - kill sets kill_pend on any cycle.
  - kill_pend clears when DYING is entered.
  - kill while in DYING is ignored and not latched.
- Timing:
  - Every state/output update happens on the clock edge where frame_tick=1.
  - Outputs are registered and change one cycle after the tick cycle (latency 1).
  - Between ticks, all outputs hold.
- Direction priority when several buttons are held: up > down > left > right. Only one axis moves per frame.
- IDLE (tick):
  - kill_pend -> DYING: death_cnt=0, sprite_num=6, alive=0, position held.
  - Else if any button -> WALK:
    - set dir
    - apply one step
    - anim_cnt=0, phase=0
    - sprite_num=dir sprite
  - Else stay; sprite_num=dir sprite.
- WALK (tick):
  - kill_pend -> DYING, as from IDLE (kill has priority over movement on the same tick).
  - No button -> IDLE: phase=0, sprite_num=dir sprite, no move.
  - Button held:
    - update dir (priority rule) and step.
    - anim_cnt increments; at ANIM_DIV-1 it wraps to 0 and phase toggles.
    - sprite_num = phase ? (dir vertical ? 4 : 5) : dir sprite.
    - A direction change does not reset anim_cnt.
- Step arithmetic:
  - Signed 12-bit intermediate: new = pos ± STEP.
  - Result is clamped to [X_MIN,X_MAX] or [Y_MIN,Y_MAX], then truncated to 11 bits.
  - At a bound the position holds, but dir and animation still update.
  - No wrap-around ever.
- DYING (tick):
  - death_cnt increments.
  - When death_cnt reaches DEATH_FRAMES-1 -> IDLE on that tick:
    - centerX/centerY=SPAWN
    - dir=DOWN, sprite_num=0, alive=1
    - anim_cnt=0, phase=0
  - Buttons are ignored while dying.
- Mid-operation reset: reset_n low at any time returns everything to reset values immediately, with no dependence on clk.
- frame_tick and kill in the same cycle: kill latches. On that tick IDLE/WALK see kill_pend=0, so the kill takes effect on the following tick.

Test Plan:
1. Reset, then hold btn_right for 3 ticks -> centerX 32→34→36→38, centerY=32, sprite_num 3,3,3 (ANIM_DIV=8), state WALK; release + 1 tick -> sprite_num=3, centerX=38.
2. Hold btn_down for 16 ticks from Y=32 -> sprite_num 0 for ticks 1-8, then 4 for ticks 9-16 (phase toggles at the 8th tick), centerY=64.
3. Start at X=766, hold btn_right for 2 ticks -> centerX=768 then 768 (clamped); start at Y=1, hold btn_up -> centerY=0, no wrap to negative.
4. Hold btn_up+btn_left together -> only Y decreases by 2 per tick, sprite_num=1.
5. While walking, pulse kill between ticks -> next tick sprite_num=6, alive=0, position frozen; after 60 ticks with buttons held -> centerX=32, centerY=32, sprite_num=0, alive=1. A second kill during dying has no effect.
6. Assert reset_n low mid-WALK, between clock edges -> outputs immediately 32/32/0/alive=1; after release, the first tick with no buttons leaves outputs unchanged.
